// File: rtl/bus_target_pkg.sv
// Shared definitions for the bus RAM target: FSM state encoding and wait-counter width.
package bus_target_pkg;

  localparam int WAIT_CNT_BITS = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/bram_single_port.sv
// Single-port synchronous RAM, read-first, no reset, so it maps onto block RAM.
module bram_single_port #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
) (
  input  logic                 i_clock,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_wdata,
  output logic [DATA_BITS-1:0] o_rdata
);

  logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_ram_target.sv
// Four-phase request/ready RAM target with optional wait states and a read-only mode.
module bus_ram_target
  import bus_target_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0,
  parameter int READ_ONLY   = 0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_bus_rw,
  input  logic        i_bus_request,
  output logic        o_bus_ready,
  input  logic [31:0] i_bus_address,
  output logic [31:0] o_bus_rdata,
  input  logic [31:0] i_bus_wdata,
  output logic        o_fault
);

  localparam logic [WAIT_CNT_BITS-1:0] WAIT_LOAD = WAIT_STATES[WAIT_CNT_BITS-1:0];

  state_t                   r_state;
  logic [WAIT_CNT_BITS-1:0] r_count;
  logic                     r_rw;
  logic [ADDR_BITS-1:0]     r_idx;
  logic [31:0]              r_wdata;
  logic                     r_ready;
  logic [31:0]              r_rdata;
  logic                     r_fault;

  logic [ADDR_BITS-1:0]     w_in_idx;
  logic [ADDR_BITS-1:0]     w_ram_addr;
  logic                     w_ram_we;
  logic [31:0]              w_ram_q;
  logic                     w_unused_addr;

  assign w_in_idx      = i_bus_address[ADDR_BITS+1:2];
  assign w_unused_addr = ^i_bus_address[31:ADDR_BITS+2];

  // The RAM is read every cycle; addressing it from the live bus in IDLE means the
  // registered read data is already valid when ACCESS is reached, even with no waits.
  assign w_ram_addr = (r_state == ST_IDLE) ? w_in_idx : r_idx;
  assign w_ram_we   = (r_state == ST_ACCESS) && r_rw && (READ_ONLY == 0);

  bram_single_port #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (32)
  ) u_ram (
    .i_clock (i_clock),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_rw    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_bus_request) begin
            r_rw    <= i_bus_rw;
            r_idx   <= w_in_idx;
            r_wdata <= i_bus_wdata;
            r_count <= WAIT_LOAD;
            if (i_bus_address[1:0] != 2'b00) begin
              r_fault <= 1'b1;
            end
            r_state <= (WAIT_LOAD != '0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (!i_bus_request) begin
            r_count <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_count <= r_count - 1'b1;
            if (r_count == 1) begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (r_rw) begin
            if (READ_ONLY != 0) begin
              r_fault <= 1'b1;
            end
          end else begin
            r_rdata <= w_ram_q;
          end
          r_ready <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!i_bus_request) begin
            r_ready <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_bus_ready = r_ready;
  assign o_bus_rdata = r_rdata;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_bus_ram_target.sv
// Directed bench: three targets (no waits, three waits, read-only) sharing one bus.
module tb_bus_ram_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  req;

  logic        ready_a, ready_b, ready_c;
  logic        fault_a, fault_b, fault_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic [31:0] pre;
  logic [31:0] post;

  always #5 clk = ~clk;

  bus_ram_target #(.ADDR_BITS(12), .WAIT_STATES(0), .READ_ONLY(0)) u_a (
    .i_clock(clk), .i_reset(rst), .i_bus_rw(rw), .i_bus_request(req[0]),
    .o_bus_ready(ready_a), .i_bus_address(addr), .o_bus_rdata(rdata_a),
    .i_bus_wdata(wdata), .o_fault(fault_a)
  );

  bus_ram_target #(.ADDR_BITS(12), .WAIT_STATES(3), .READ_ONLY(0)) u_b (
    .i_clock(clk), .i_reset(rst), .i_bus_rw(rw), .i_bus_request(req[1]),
    .o_bus_ready(ready_b), .i_bus_address(addr), .o_bus_rdata(rdata_b),
    .i_bus_wdata(wdata), .o_fault(fault_b)
  );

  bus_ram_target #(.ADDR_BITS(12), .WAIT_STATES(0), .READ_ONLY(1)) u_c (
    .i_clock(clk), .i_reset(rst), .i_bus_rw(rw), .i_bus_request(req[2]),
    .o_bus_ready(ready_c), .i_bus_address(addr), .o_bus_rdata(rdata_c),
    .i_bus_wdata(wdata), .o_fault(fault_c)
  );

  function automatic logic ready_of(input int u);
    case (u)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int u);
    case (u)
      0:       return rdata_a;
      1:       return rdata_b;
      default: return rdata_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %-12s observed %08h expected %08h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One handshake: request raised after a falling edge; ready must first appear after
  // 'lat' rising edges, stay up for 'hold' more cycles, and drop one edge after release.
  task automatic txn(input int u, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input int lat, input int hold, output logic [31:0] rdo);
    @(negedge clk);
    rw = w; addr = a; wdata = wd; req[u] = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rw = ~w; addr = ~a; wdata = ~wd;
      end
      if (k < lat) chk("early_rdy", {31'd0, ready_of(u)}, 32'd0);
      else         chk("rdy", {31'd0, ready_of(u)}, 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rdy", {31'd0, ready_of(u)}, 32'd1);
    end
    rdo = rdata_of(u);
    req[u] = 1'b0;
    @(negedge clk);
    chk("rel_rdy", {31'd0, ready_of(u)}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; rw = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy_a", {31'd0, ready_a}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_fault_a", {31'd0, fault_a}, 32'd0);
    chk("rst_rdy_b", {31'd0, ready_b}, 32'd0);
    chk("rst_fault_c", {31'd0, fault_c}, 32'd0);
    rst = 1'b0;

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 0, rd);
    txn(0, 1'b0, 32'h10, 32'h0, 2, 0, rd);
    chk("w0_read", rd, 32'hDEADBEEF);
    chk("w0_fault", {31'd0, fault_a}, 32'd0);

    txn(1, 1'b1, 32'h0, 32'h0BADF00D, 5, 0, rd);
    txn(1, 1'b0, 32'h0, 32'h0, 5, 2, rd);
    chk("ws3_read", rd, 32'h0BADF00D);

    txn(1, 1'b1, 32'h20, 32'h11112222, 5, 0, rd);
    @(negedge clk);
    rw = 1'b1; addr = 32'h20; wdata = 32'h12345678; req[1] = 1'b1;
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_rdy", {31'd0, ready_b}, 32'd0);
    end
    txn(1, 1'b0, 32'h20, 32'h0, 5, 0, rd);
    chk("abort_read", rd, 32'h11112222);
    chk("ws3_fault", {31'd0, fault_b}, 32'd0);

    txn(0, 1'b1, 32'h22, 32'hA5A5A5A5, 2, 0, rd);
    chk("wr_keeps_rd", rd, 32'hDEADBEEF);
    chk("mis_fault", {31'd0, fault_a}, 32'd1);
    txn(0, 1'b0, 32'h20, 32'h0, 2, 0, rd);
    chk("mis_read", rd, 32'hA5A5A5A5);

    txn(2, 1'b0, 32'h4, 32'h0, 2, 0, pre);
    chk("ro_fault0", {31'd0, fault_c}, 32'd0);
    txn(2, 1'b1, 32'h4, 32'hFFFFFFFF, 2, 0, rd);
    chk("ro_fault1", {31'd0, fault_c}, 32'd1);
    chk("ro_wr_rdata", rd, pre);
    txn(2, 1'b0, 32'h4, 32'h0, 2, 0, post);
    chk("ro_read", post, pre);

    @(negedge clk);
    rw = 1'b0; addr = 32'h20; req[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_rdy", {31'd0, ready_a}, 32'd1);
    chk("pre_rst_data", rdata_a, 32'hA5A5A5A5);
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", {31'd0, ready_a}, 32'd0);
    chk("arst_rdata", rdata_a, 32'd0);
    chk("arst_fault", {31'd0, fault_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req[0] = 1'b0;
    txn(0, 1'b0, 32'h10, 32'h0, 2, 0, rd);
    chk("post_rst_rd", rd, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
